// File: rtl/bus_fifo_lvl.sv
// Single-clock show-ahead bus FIFO with occupancy level, almost-full/empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
module bus_fifo_lvl #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              DATA_STROBE,
   input  logic [WIDTH-1:0]  DATA_IN,
   output logic              FULL,
   output logic              DATA_READY,
   output logic [WIDTH-1:0]  DATA_OUT,
   input  logic              DATA_ACK,
   input  logic              FLUSH,
   input  logic [ADDR_W:0]   AFULL_LVL,
   input  logic [ADDR_W:0]   AEMPTY_LVL,
   output logic [ADDR_W:0]   LEVEL,
   output logic              ALMOST_FULL,
   output logic              ALMOST_EMPTY,
   output logic              OVERFLOW,
   output logic              UNDERFLOW,
   input  logic              ERR_CLR
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned PW    = ADDR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [ADDR_W:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0] wr_ptr_nxt, rd_ptr_nxt, level_nxt;
   logic            ovf_nxt, udf_nxt;
   logic            empty;
   logic            wr_en, rd_en, ovf_set, udf_set;

   // Status from registered pointers only; wrap bit separates full from empty
   always_comb begin
      empty        = (wr_ptr == rd_ptr);
      FULL         = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                     (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
      DATA_READY   = !empty;
      DATA_OUT     = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
      ALMOST_FULL  = (LEVEL >= AFULL_LVL);
      ALMOST_EMPTY = (LEVEL <= AEMPTY_LVL);
   end

   // Accept/error qualification; flush suppresses both transfers and errors
   always_comb begin
      wr_en   = DATA_STROBE && !FULL  && !FLUSH;
      rd_en   = DATA_ACK    && !empty && !FLUSH;
      ovf_set = DATA_STROBE &&  FULL  && !FLUSH;
      udf_set = DATA_ACK    &&  empty && !FLUSH;
   end

   // Next pointer/level/flag values
   always_comb begin
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      level_nxt  = LEVEL;
      ovf_nxt    = OVERFLOW;
      udf_nxt    = UNDERFLOW;
      if (FLUSH) begin
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
         level_nxt  = '0;
      end else begin
         if (wr_en) wr_ptr_nxt = wr_ptr + PW'(1);
         if (rd_en) rd_ptr_nxt = rd_ptr + PW'(1);
         if (wr_en && !rd_en)      level_nxt = LEVEL + PW'(1);
         else if (rd_en && !wr_en) level_nxt = LEVEL - PW'(1);
      end
      // Set beats clear when both happen in one cycle
      if (ERR_CLR) begin
         ovf_nxt = 1'b0;
         udf_nxt = 1'b0;
      end
      if (ovf_set) ovf_nxt = 1'b1;
      if (udf_set) udf_nxt = 1'b1;
   end

   // Pointer, level and sticky flag registers
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         LEVEL     <= '0;
         OVERFLOW  <= 1'b0;
         UNDERFLOW <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         LEVEL     <= level_nxt;
         OVERFLOW  <= ovf_nxt;
         UNDERFLOW <= udf_nxt;
      end
   end

   // Storage array, not reset
   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= DATA_IN;
   end

endmodule

// File: tb/tb_bus_fifo_lvl.sv
// Directed self-checking bench for bus_fifo_lvl (WIDTH=8, ADDR_W=3).
module tb_bus_fifo_lvl;

   logic       clk;
   logic       rst_n;
   logic       stb;
   logic [7:0] din;
   logic       full;
   logic       rdy;
   logic [7:0] dout;
   logic       ack;
   logic       flush;
   logic [3:0] afull_lvl;
   logic [3:0] aempty_lvl;
   logic [3:0] level;
   logic       afull;
   logic       aempty;
   logic       ovf;
   logic       udf;
   logic       err_clr;

   int total = 0;
   int bad   = 0;

   bus_fifo_lvl #(.WIDTH(8), .ADDR_W(3)) dut (
      .CLK         (clk),
      .RESET_N     (rst_n),
      .DATA_STROBE (stb),
      .DATA_IN     (din),
      .FULL        (full),
      .DATA_READY  (rdy),
      .DATA_OUT    (dout),
      .DATA_ACK    (ack),
      .FLUSH       (flush),
      .AFULL_LVL   (afull_lvl),
      .AEMPTY_LVL  (aempty_lvl),
      .LEVEL       (level),
      .ALMOST_FULL (afull),
      .ALMOST_EMPTY(aempty),
      .OVERFLOW    (ovf),
      .UNDERFLOW   (udf),
      .ERR_CLR     (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       stb;
      logic [7:0] din;
      logic       ack;
      logic       clr;
      logic       full;
      logic       rdy;
      logic [7:0] dout;
      logic [3:0] lvl;
      logic       af;
      logic       ae;
      logic       ovf;
      logic       udf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic s, logic [7:0] d, logic a, logic c,
                               logic f, logic r, logic [7:0] o, logic [3:0] l,
                               logic xaf, logic xae, logic xo, logic xu);
      vec_t v;
      v.stb = s; v.din = d; v.ack = a; v.clr = c;
      v.full = f; v.rdy = r; v.dout = o; v.lvl = l;
      v.af = xaf; v.ae = xae; v.ovf = xo; v.udf = xu;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Packed snapshot: full,rdy,dout,level,af,ae,ovf,udf
   function automatic logic [31:0] snap();
      return 32'({full, rdy, dout, level, afull, aempty, ovf, udf});
   endfunction

   function automatic logic [31:0] pack_exp(logic f, logic r, logic [7:0] o, logic [3:0] l,
                                            logic xaf, logic xae, logic xo, logic xu);
      return 32'({f, r, o, l, xaf, xae, xo, xu});
   endfunction

   task automatic step(input logic s, input logic [7:0] d, input logic a,
                       input logic fl, input logic c);
      stb = s; din = d; ack = a; flush = fl; err_clr = c;
      @(posedge clk);
      #1;
      stb = 1'b0; ack = 1'b0; flush = 1'b0; err_clr = 1'b0;
   endtask

   logic [7:0] exp_q[$];

   initial begin
      rst_n = 1'b0; stb = 1'b0; din = '0; ack = 1'b0; flush = 1'b0; err_clr = 1'b0;
      afull_lvl = 4'd0; aempty_lvl = 4'd2;

      // Fill/drain/boundary table, thresholds AF=6 AE=2
      vecs.push_back(mk(1,8'h01,0,0, 0,1,8'h01,4'd1,0,1,0,0));
      vecs.push_back(mk(1,8'h02,0,0, 0,1,8'h01,4'd2,0,1,0,0));
      vecs.push_back(mk(1,8'h03,0,0, 0,1,8'h01,4'd3,0,0,0,0));
      vecs.push_back(mk(1,8'h04,0,0, 0,1,8'h01,4'd4,0,0,0,0));
      vecs.push_back(mk(1,8'h05,0,0, 0,1,8'h01,4'd5,0,0,0,0));
      vecs.push_back(mk(1,8'h06,0,0, 0,1,8'h01,4'd6,1,0,0,0));
      vecs.push_back(mk(1,8'h07,0,0, 0,1,8'h01,4'd7,1,0,0,0));
      vecs.push_back(mk(1,8'h08,0,0, 1,1,8'h01,4'd8,1,0,0,0));
      vecs.push_back(mk(1,8'h09,0,0, 1,1,8'h01,4'd8,1,0,1,0));
      vecs.push_back(mk(0,8'h00,1,0, 0,1,8'h02,4'd7,1,0,1,0));
      vecs.push_back(mk(0,8'h00,1,0, 0,1,8'h03,4'd6,1,0,1,0));
      vecs.push_back(mk(0,8'h00,1,0, 0,1,8'h04,4'd5,0,0,1,0));
      vecs.push_back(mk(0,8'h00,1,0, 0,1,8'h05,4'd4,0,0,1,0));
      vecs.push_back(mk(0,8'h00,1,0, 0,1,8'h06,4'd3,0,0,1,0));
      vecs.push_back(mk(0,8'h00,1,0, 0,1,8'h07,4'd2,0,1,1,0));
      vecs.push_back(mk(0,8'h00,1,0, 0,1,8'h08,4'd1,0,1,1,0));
      vecs.push_back(mk(0,8'h00,1,0, 0,0,8'h00,4'd0,0,1,1,0));
      vecs.push_back(mk(0,8'h00,0,1, 0,0,8'h00,4'd0,0,1,0,0));
      vecs.push_back(mk(0,8'h00,1,0, 0,0,8'h00,4'd0,0,1,0,1));
      vecs.push_back(mk(1,8'h55,1,0, 0,1,8'h55,4'd1,0,1,0,1));
      vecs.push_back(mk(0,8'h00,1,0, 0,0,8'h00,4'd0,0,1,0,1));
      vecs.push_back(mk(0,8'h00,0,1, 0,0,8'h00,4'd0,0,1,0,0));

      // Reset state, with AFULL_LVL=0 then 6
      #3;
      chk("reset_state", snap(), pack_exp(0,0,8'h00,4'd0,1,1,0,0));
      afull_lvl = 4'd6;
      #1;
      chk("reset_af_lvl6", 32'(afull), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         step(vecs[i].stb, vecs[i].din, vecs[i].ack, 1'b0, vecs[i].clr);
         chk($sformatf("vec%0d", i), snap(),
             pack_exp(vecs[i].full, vecs[i].rdy, vecs[i].dout, vecs[i].lvl,
                      vecs[i].af, vecs[i].ae, vecs[i].ovf, vecs[i].udf));
      end

      // Wrap-around: steady LEVEL 3 streaming across pointer wraps
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      chk("wrap_prefill_lvl", 32'(level), 32'd3);
      for (int j = 0; j < 20; j++) begin
         step(1'b1, 8'(8'h13 + j), 1'b1, 1'b0, 1'b0);
         chk($sformatf("wrap_dout%0d", j), 32'(dout), 32'(8'h10 + j + 1));
         chk($sformatf("wrap_lvl%0d", j), 32'({full, level}), 32'd3);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("wrap_drain1", 32'(dout), 32'h25);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("wrap_drain2", 32'(dout), 32'h26);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("wrap_drain3", 32'({rdy, dout}), 32'h000);

      // Full boundary: simultaneous strobe+ack at full, ERR_CLR vs new overflow
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
      chk("full_fill", 32'({full, level}), 32'h18);
      step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
      chk("full_rdwr", snap(), pack_exp(0,1,8'hB1,4'd7,1,0,1,0));
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("full_errclr", 32'({ovf, udf}), 32'd0);
      step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      chk("full_refill", 32'({full, level}), 32'h18);
      step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
      chk("set_beats_clr", 32'({ovf, level}), 32'h18);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("errclr_after", 32'(ovf), 32'd0);
      afull_lvl = 4'd9; aempty_lvl = 4'd9;
      #1;
      chk("thresh_above_depth", 32'({full, afull, aempty}), 32'b101);
      afull_lvl = 4'd6; aempty_lvl = 4'd2;
      for (int i = 1; i < 8; i++) exp_q.push_back(8'(8'hB0 + i));
      exp_q.push_back(8'hAA);
      foreach (exp_q[i]) begin
         chk($sformatf("full_drain%0d", i), 32'(dout), 32'(exp_q[i]));
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      chk("full_drained", 32'({rdy, level}), 32'd0);

      // Flush overrides strobe and ack, sets no flags
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
      chk("flush_pre_lvl", 32'(level), 32'd5);
      step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
      chk("flush", snap(), pack_exp(0,0,8'h00,4'd0,0,1,0,0));
      step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
      chk("flush_after_wr", 32'({rdy, dout, level}), 32'h13C1);

      // Async reset mid-cycle at LEVEL=4 with OVERFLOW set
      for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("pre_reset", 32'({ovf, level}), 32'h14);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_reset", snap(), pack_exp(0,0,8'h00,4'd0,0,1,0,0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 8'hE0, 1'b0, 1'b0, 1'b0);
      chk("post_reset_wr", 32'({rdy, dout, level}), 32'h1E01);
      step(1'b1, 8'hE1, 1'b1, 1'b0, 1'b0);
      chk("post_reset_rdwr", 32'({dout, level}), 32'hE11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_fifo_lvl.md
Name: bus_fifo_lvl

Overview:
- Next-generation bus FIFO for the processor-design bus fabric.
- Single-clock show-ahead FIFO, parametrised in data width and address width.
- Uses the full power-of-two capacity via wrap-bit pointers.
- Adds occupancy level, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags for bus monitors and DMA throttling.

Parameters:
- WIDTH, 8, data word width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries, all usable.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- DATA_STROBE  in  1  write request.
- DATA_IN  in  WIDTH  write data.
- FULL  out  1  FIFO holds DEPTH entries.
- DATA_READY  out  1  FIFO non-empty; DATA_OUT valid.
- DATA_OUT  out  WIDTH  head entry (show-ahead).
- DATA_ACK  in  1  pop head entry.
- FLUSH  in  1  synchronous empty request.
- AFULL_LVL  in  ADDR_W+1  almost-full threshold.
- AEMPTY_LVL  in  ADDR_W+1  almost-empty threshold.
- LEVEL  out  ADDR_W+1  current occupancy, 0..DEPTH.
- ALMOST_FULL  out  1  LEVEL >= AFULL_LVL.
- ALMOST_EMPTY  out  1  LEVEL <= AEMPTY_LVL.
- OVERFLOW  out  1  sticky: write attempted while full.
- UNDERFLOW  out  1  sticky: ack attempted while empty.
- ERR_CLR  in  1  clears OVERFLOW/UNDERFLOW.

Behaviour:
- Reset: CLK is the single clock. RESET_N is asynchronous, active-low; assertion immediately clears wr_ptr, rd_ptr, LEVEL, OVERFLOW and UNDERFLOW.
  - Resulting output values: FULL=0, DATA_READY=0, DATA_OUT=0, ALMOST_EMPTY=1, ALMOST_FULL=(AFULL_LVL==0).
  - Memory array is not reset. Deassertion is released on the CLK edge domain.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits. The low ADDR_W bits index memory; the MSB is the wrap bit. Increment is +1 modulo 2**(ADDR_W+1).
- Status derivation (combinational from registered state only, never from same-cycle inputs):
  - empty = (wr_ptr == rd_ptr).
  - FULL = (low bits equal and wrap bits differ).
  - DATA_READY = !empty.
- Write: accepted when DATA_STROBE & !FULL. DATA_IN is stored at mem[wr_ptr]; wr_ptr increments.
- Read: accepted when DATA_ACK & DATA_READY; rd_ptr increments.
  - DATA_OUT = mem[rd_ptr[ADDR_W-1:0]] when DATA_READY, else all zeros (no tristate).
  - The first written word appears on DATA_OUT one cycle after its strobe edge. There is no same-cycle bypass.
- Simultaneous write and read:
  - When not full and not empty: both occur; LEVEL unchanged.
  - At full: read accepted, write rejected (FULL is registered-state based); OVERFLOW sets.
  - At empty: write accepted, ack ignored; UNDERFLOW sets.
- LEVEL: registered. +1 on write-only, -1 on read-only, unchanged otherwise. Always equals wr_ptr - rd_ptr.
- Thresholds: ALMOST_FULL and ALMOST_EMPTY are unsigned compares of registered LEVEL against live threshold inputs.
  - Threshold values above DEPTH are legal: ALMOST_FULL never asserts; ALMOST_EMPTY always asserts.
- FLUSH: synchronous. On the edge, wr_ptr=rd_ptr=0 and LEVEL=0.
  - Overrides same-cycle DATA_STROBE and DATA_ACK (neither takes effect, no error flags set).
  - Memory contents are untouched. Sticky flags are unaffected.
- Error flags:
  - OVERFLOW sets on DATA_STROBE & FULL (without FLUSH).
  - UNDERFLOW sets on DATA_ACK & empty (without FLUSH).
  - Both hold until ERR_CLR. If set and ERR_CLR occur in the same cycle, set wins.
- Reset mid-operation: asynchronous assertion empties the FIFO immediately regardless of pending strobe/ack. First valid write is the first edge after release.
- No state machine beyond pointers/level/flags. Throughput is one write and one read per cycle sustained.

Test Plan:
- Fill (WIDTH=8, ADDR_W=3): strobe 0x01..0x08 on 8 consecutive cycles -> FULL=1 and LEVEL=8 after 8th edge. 9th strobe 0x09 dropped and OVERFLOW=1. Ack 8 times -> DATA_OUT sequence 0x01..0x08, then DATA_READY=0, DATA_OUT=0x00.
- Wrap-around: 20 items written and read continuously at LEVEL 3 -> data order preserved across two pointer wraps, FULL never asserts, LEVEL stays 3.
- Boundaries: at full, strobe 0xAA + ack same cycle -> head popped, 0xAA dropped, LEVEL=7, OVERFLOW=1. At empty, strobe 0x55 + ack -> LEVEL=1, DATA_OUT=0x55 next cycle, UNDERFLOW=1. Then ERR_CLR -> both flags 0; ERR_CLR concurrent with new overflow -> OVERFLOW stays 1.
- Thresholds: AFULL_LVL=6, AEMPTY_LVL=2.
  - Writing 6 items -> ALMOST_EMPTY drops after 3rd write; ALMOST_FULL rises after 6th.
  - AFULL_LVL=9 -> ALMOST_FULL never asserts at full.
- Flush: LEVEL=5, assert FLUSH with DATA_STROBE and DATA_ACK -> next cycle LEVEL=0, DATA_READY=0, no flags set. Subsequent write 0x3C appears at DATA_OUT.
- Async reset: assert RESET_N=0 mid-cycle at LEVEL=4 with OVERFLOW=1 -> outputs clear without a clock edge (DATA_READY=0, LEVEL=0, OVERFLOW=0). After release, normal fill resumes from entry 0.
